// File: rtl/mem_if_resp.sv
// mem_if_resp: on-chip stand-in for the frame buffer's external memory controller.
// Optional periodic refresh stalls are enabled by defining MEM_IF_RESP_REFRESH_EN.
module mem_if_resp #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 29,
  parameter int unsigned MEM_ADDR_WIDTH = 12,
  parameter int unsigned RD_LATENCY     = 4,
  parameter int unsigned INIT_CYCLES    = 16,
  parameter int unsigned REFRESH_PERIOD = 1024,
  parameter int unsigned REFRESH_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  wr_rdy,
  output logic                  rd_rdy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid
);

  localparam int unsigned MEM_DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam int unsigned INIT_W    = $clog2(INIT_CYCLES + 2);
  localparam logic        GRANT_READ  = 1'b0;
  localparam logic        GRANT_WRITE = 1'b1;

`ifdef MEM_IF_RESP_REFRESH_EN
  typedef enum logic [1:0] {
    ST_INIT    = 2'b00,
    ST_ACTIVE  = 2'b01,
    ST_REFRESH = 2'b10
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_INIT    = 2'b00,
    ST_ACTIVE  = 2'b01
  } state_t;
`endif

  state_t                state;
  state_t                state_next;
  logic [INIT_W-1:0]     init_cnt;
  logic                  last_grant;
  logic                  wr_req;
  logic                  rd_req;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] pipe_data [RD_LATENCY];
  logic [RD_LATENCY-1:0] pipe_valid;
  logic                  unused_addr_bits;

  assign wr_req = ~wr_en;
  assign rd_req = ~rd_en;
  assign wr_acc = wr_rdy & reset;
  assign rd_acc = rd_rdy & reset;

  // Upper request address bits alias onto the backing store.
  assign unused_addr_bits = ^{wr_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                              rd_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH]};

`ifdef MEM_IF_RESP_REFRESH_EN
  localparam int unsigned PERIOD_W = $clog2(REFRESH_PERIOD + 1);
  localparam int unsigned STALL_W  = $clog2(REFRESH_CYCLES + 1);

  logic [PERIOD_W-1:0] period_cnt;
  logic [STALL_W-1:0]  stall_cnt;

  // Period counter runs from the first ACTIVE cycle and restarts on each refresh entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      period_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (state == ST_INIT || (state == ST_ACTIVE && state_next == ST_REFRESH)) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + PERIOD_W'(1);
      end
      if (state == ST_REFRESH) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end else begin
        stall_cnt <= '0;
      end
    end
  end
`else
  localparam int unsigned UNUSED_REFRESH_CFG = REFRESH_PERIOD + REFRESH_CYCLES;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next state and arbitrated readies; alternate grants when both requests are pending.
  always_comb begin
    state_next = state;
    wr_rdy     = 1'b0;
    rd_rdy     = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_cnt == INIT_W'(INIT_CYCLES)) begin
          state_next = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (wr_req && (!rd_req || last_grant == GRANT_READ)) begin
          wr_rdy = 1'b1;
        end else if (rd_req) begin
          rd_rdy = 1'b1;
        end
`ifdef MEM_IF_RESP_REFRESH_EN
        if (period_cnt == PERIOD_W'(REFRESH_PERIOD - 1)) begin
          state_next = ST_REFRESH;
        end
`endif
      end
`ifdef MEM_IF_RESP_REFRESH_EN
      ST_REFRESH: begin
        if (stall_cnt == STALL_W'(REFRESH_CYCLES - 1)) begin
          state_next = ST_ACTIVE;
        end
      end
`endif
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // Calibration counter, held at zero outside INIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + INIT_W'(1);
    end else begin
      init_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= GRANT_READ;
    end else if (wr_rdy) begin
      last_grant <= GRANT_WRITE;
    end else if (rd_rdy) begin
      last_grant <= GRANT_READ;
    end
  end

  // Backing store, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_addr[MEM_ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // Read pipeline: store read at accept, last stage is the output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= rd_acc;
      pipe_data[0]  <= rd_acc ? mem[rd_addr[MEM_ADDR_WIDTH-1:0]] : '0;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign rd_data       = pipe_data[RD_LATENCY-1];
  assign rd_data_valid = pipe_valid[RD_LATENCY-1];

endmodule
